// File: rtl/mem_arbiter.sv
// Two-port (instruction/data cache) line arbiter in front of a single memory port.
// Round-robin on ties; the granted request is captured so requesters may change freely.
module mem_arbiter #(
   parameter int unsigned ADDR_W = 28,
   parameter int unsigned DATA_W = 128
) (
   input  logic              clk,
   input  logic              proc_reset,

   input  logic              i_read,
   input  logic              i_write,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_ready,

   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ready,

   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   typedef enum logic [1:0] {StIdle, StGrantI, StGrantD, StResp} state_e;

   state_e              state_q;
   logic                last_grant_d_q;  // 0: I-port granted last, 1: D-port
   logic                op_write_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   i_rdata_q;
   logic [DATA_W-1:0]   d_rdata_q;
   logic                i_ready_q;
   logic                d_ready_q;

   logic i_req;
   logic d_req;
   logic grant_d;
   logic in_grant;

   assign i_req = i_read | i_write;
   assign d_req = d_read | d_write;

   // D wins only when I is idle, or on a tie when I was served last.
   assign grant_d  = d_req & (~i_req | ~last_grant_d_q);
   assign in_grant = (state_q == StGrantI) || (state_q == StGrantD);

   always_ff @(posedge clk) begin
      if (proc_reset) begin
         state_q        <= StIdle;
         last_grant_d_q <= 1'b0;
         op_write_q     <= 1'b0;
         addr_q         <= '0;
         wdata_q        <= '0;
         i_rdata_q      <= '0;
         d_rdata_q      <= '0;
         i_ready_q      <= 1'b0;
         d_ready_q      <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (i_req || d_req) begin
                  last_grant_d_q <= grant_d;
                  if (grant_d) begin
                     state_q    <= StGrantD;
                     op_write_q <= d_write;
                     addr_q     <= d_addr;
                     wdata_q    <= d_wdata;
                  end else begin
                     state_q    <= StGrantI;
                     op_write_q <= i_write;
                     addr_q     <= i_addr;
                     wdata_q    <= i_wdata;
                  end
               end
            end
            StGrantI: begin
               if (mem_ready) begin
                  state_q   <= StResp;
                  i_ready_q <= 1'b1;
                  if (!op_write_q) i_rdata_q <= mem_rdata;
               end
            end
            StGrantD: begin
               if (mem_ready) begin
                  state_q   <= StResp;
                  d_ready_q <= 1'b1;
                  if (!op_write_q) d_rdata_q <= mem_rdata;
               end
            end
            StResp: begin
               state_q   <= StIdle;
               i_ready_q <= 1'b0;
               d_ready_q <= 1'b0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Strobes drop in the same cycle mem_ready arrives so memory sees one request per grant.
   assign mem_read  = in_grant & ~op_write_q & ~mem_ready;
   assign mem_write = in_grant &  op_write_q & ~mem_ready;
   assign mem_addr  = in_grant ? addr_q  : '0;
   assign mem_wdata = in_grant ? wdata_q : '0;

   assign i_rdata = i_rdata_q;
   assign d_rdata = d_rdata_q;
   assign i_ready = i_ready_q;
   assign d_ready = d_ready_q;

endmodule
